// File: rtl/alu_operand_stage_if.sv
// Decode-to-execute operand bus: request fields and forwarding ports from decode,
// registered operands and valid/ready handshake toward execute.
interface alu_operand_stage_if #(
    parameter int WIDTH    = 32,
    parameter int FWD_SRCS = 2,
    parameter int REG_AW   = 5
);
    logic                       in_valid;
    logic                       in_ready;
    logic                       flush;
    logic [WIDTH-1:0]           pc;
    logic [31:0]                instruction;
    logic [WIDTH-1:0]           reg_s_value;
    logic [WIDTH-1:0]           reg_t_value;
    logic [REG_AW-1:0]          reg_s_num;
    logic [REG_AW-1:0]          reg_t_num;
    logic [1:0]                 alu_x;
    logic [2:0]                 alu_y;
    logic [FWD_SRCS-1:0]        fwd_valid;
    logic [FWD_SRCS*REG_AW-1:0] fwd_num;
    logic [FWD_SRCS*WIDTH-1:0]  fwd_data;
    logic                       out_valid;
    logic                       out_ready;
    logic [WIDTH-1:0]           result_x;
    logic [WIDTH-1:0]           result_y;
    logic [1:0]                 fwd_hit;

    modport master (
        output in_valid, flush, pc, instruction, reg_s_value, reg_t_value,
               reg_s_num, reg_t_num, alu_x, alu_y, fwd_valid, fwd_num, fwd_data,
               out_ready,
        input  in_ready, out_valid, result_x, result_y, fwd_hit
    );

    modport slave (
        input  in_valid, flush, pc, instruction, reg_s_value, reg_t_value,
               reg_s_num, reg_t_num, alu_x, alu_y, fwd_valid, fwd_num, fwd_data,
               out_ready,
        output in_ready, out_valid, result_x, result_y, fwd_hit
    );
endinterface

// File: rtl/alu_operand_stage.sv
// Operand-select stage: picks ALU X/Y operands with prioritised RAW forwarding
// and holds them in a one-entry valid/ready register between decode and execute.
module alu_operand_stage #(
    parameter int WIDTH    = 32,
    parameter int FWD_SRCS = 2,
    parameter int REG_AW   = 5
) (
    input logic                clk,
    input logic                rst,
    alu_operand_stage_if.slave bus
);
    typedef logic [WIDTH-1:0]  word_t;
    typedef logic [REG_AW-1:0] regNum_t;

    // Returns {hit, value}; the lowest-indexed matching source wins, r0 never matches.
    function automatic logic [WIDTH:0] resolveFwd(
        input regNum_t                    num,
        input word_t                      regValue,
        input logic [FWD_SRCS-1:0]        fwdValid,
        input logic [FWD_SRCS*REG_AW-1:0] fwdNum,
        input logic [FWD_SRCS*WIDTH-1:0]  fwdData
    );
        logic [WIDTH:0] res;
        res = {1'b0, regValue};
        for (int i = FWD_SRCS - 1; i >= 0; i--) begin
            if (fwdValid[i] && (num != '0) && (fwdNum[i*REG_AW +: REG_AW] == num)) begin
                res = {1'b1, fwdData[i*WIDTH +: WIDTH]};
            end
        end
        return res;
    endfunction

    function automatic word_t signExtImm(input logic [15:0] imm);
        return {{(WIDTH-16){imm[15]}}, imm};
    endfunction

    function automatic word_t zeroExtImm(input logic [15:0] imm);
        return word_t'(imm);
    endfunction

    function automatic word_t luiImm(input logic [15:0] imm);
        return word_t'({imm, 16'h0000});
    endfunction

    function automatic word_t shamtField(input logic [4:0] shamt);
        return word_t'(shamt);
    endfunction

    logic [31:0]    instr;
    logic [15:0]    imm;
    logic           unusedInstrBits;
    logic [WIDTH:0] fwdS;
    logic [WIDTH:0] fwdT;
    word_t          opS;
    word_t          opT;
    logic           hitS;
    logic           hitT;
    word_t          selX;
    word_t          selY;
    logic           capture;

    logic           vld_p1;
    word_t          resultX_p1;
    word_t          resultY_p1;
    logic [1:0]     fwdHit_p1;

    // ---- stage p0: forwarding resolution and operand select ----
    assign instr           = bus.instruction;
    assign imm             = instr[15:0];
    assign unusedInstrBits = ^instr[31:16];

    assign fwdS = resolveFwd(bus.reg_s_num, bus.reg_s_value,
                             bus.fwd_valid, bus.fwd_num, bus.fwd_data);
    assign fwdT = resolveFwd(bus.reg_t_num, bus.reg_t_value,
                             bus.fwd_valid, bus.fwd_num, bus.fwd_data);
    assign {hitS, opS} = fwdS;
    assign {hitT, opT} = fwdT;

    always_comb begin
        selX = '0;
        case (bus.alu_x)
            2'd0:    selX = opS;
            2'd1:    selX = opT;
            2'd2:    selX = bus.pc;
            2'd3:    selX = shamtField(instr[10:6]);
            default: selX = '0;
        endcase
    end

    always_comb begin
        selY = '0;
        case (bus.alu_y)
            3'd0:    selY = opT;
            3'd1:    selY = signExtImm(imm);
            3'd2:    selY = zeroExtImm(imm);
            3'd3:    selY = luiImm(imm);
            3'd4:    selY = word_t'(4);
            default: selY = '0;
        endcase
    end

    // A held entry frees the slot in the same cycle it is consumed, so flow never bubbles.
    assign bus.in_ready = !vld_p1 || bus.out_ready;
    assign capture      = bus.in_valid && bus.in_ready && !bus.flush;

    // ---- stage p1: operand register toward execute ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1     <= 1'b0;
            resultX_p1 <= '0;
            resultY_p1 <= '0;
            fwdHit_p1  <= 2'b00;
        end else if (bus.flush) begin
            vld_p1 <= 1'b0;
        end else if (capture) begin
            vld_p1     <= 1'b1;
            resultX_p1 <= selX;
            resultY_p1 <= selY;
            fwdHit_p1  <= {hitT, hitS};
        end else if (bus.out_ready) begin
            vld_p1 <= 1'b0;
        end
    end

    assign bus.out_valid = vld_p1;
    assign bus.result_x  = resultX_p1;
    assign bus.result_y  = resultY_p1;
    assign bus.fwd_hit   = fwdHit_p1;
endmodule
